// File: rtl/miniled_pkg.sv
// Shared FSM state encoding and counter sizing helper for the mini-LED scan driver.
package miniled_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_LATCH   = 3'd3;
  localparam logic [2:0] ST_DISPLAY = 3'd4;
  localparam logic [2:0] ST_BLANK   = 3'd5;

  // Bits needed for a counter running 0..n-1, never narrower than 1.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/miniled_scan_driver_if.sv
// Frame-buffer read port: address out, lane-packed data back one cycle later.
interface miniled_scan_driver_if #(
  parameter int IDX_W    = 9,
  parameter int CHAN_NUM = 1,
  parameter int DATA_W   = 16
);
  import miniled_pkg::*;

  logic [IDX_W-1:0]           light_index;
  logic [CHAN_NUM*DATA_W-1:0] mapped_light;

  modport master (output light_index, input mapped_light);
  modport slave  (input light_index, output mapped_light);

endinterface

// File: rtl/miniled_clk_phase.sv
// CLK_DIV-cycle phase counter shared by shift, latch and grayscale clocking;
// restarts at phase 0 whenever en_i drops.
module miniled_clk_phase
  import miniled_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic first_half_o,
  output logic period_end_o
);

  localparam int CW = cnt_w(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || period_end_o) cnt_d = '0;
    else                       cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign first_half_o = en_i && (cnt_q < CW'(CLK_DIV / 2));
  assign period_end_o = en_i && (cnt_q == CW'(CLK_DIV - 1));

endmodule

// File: rtl/miniled_scan_driver.sv
// Mini-LED scan driver: fetch words, shift them out per lane, latch, then light one row with GCLK.
// Define SCAN_BLANK_EN to stretch the inter-row blank to BLANK_CYC cycles (default: 1 cycle).
module miniled_scan_driver
  import miniled_pkg::*;
#(
  parameter int SCAN_NUM     = 4,
  parameter int CHAN_NUM     = 1,
  parameter int LED_PER_CHAN = 128,
  parameter int DATA_W       = 16,
  parameter int IDX_W        = 9,
  parameter int CLK_DIV      = 4,
  parameter int GCLK_PULSES  = 256,
  parameter int BLANK_CYC    = 8
) (
  input  logic                I_clk,
  input  logic                sys_rst,
  input  logic                light_refresh,
  miniled_scan_driver_if.master fb,
  output logic                LE,
  output logic                DCLK,
  output logic [CHAN_NUM-1:0] SDI,
  output logic                GCLK,
  output logic [SCAN_NUM-1:0] scan,
  output logic                busy,
  output logic                frame_done
);

  localparam int SW = cnt_w(SCAN_NUM);
  localparam int WW = cnt_w(LED_PER_CHAN);
  localparam int BW = cnt_w(DATA_W);
  localparam int PW = cnt_w(GCLK_PULSES);

  if (SCAN_NUM * LED_PER_CHAN > 2 ** IDX_W) begin : g_bad_idx
    $error("IDX_W too narrow for SCAN_NUM*LED_PER_CHAN");
  end
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("CLK_DIV must be even and >= 2");
  end
  if (BLANK_CYC < 1) begin : g_bad_blank
    $error("BLANK_CYC must be >= 1");
  end

  logic [2:0]                       state_q, state_d;
  logic [SW-1:0]                    s_q, s_d;
  logic [WW-1:0]                    w_q, w_d;
  logic [BW-1:0]                    bit_q, bit_d;
  logic [PW-1:0]                    pls_q, pls_d;
  logic                             fph_q, fph_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [CHAN_NUM-1:0][DATA_W-1:0]  sr_q, sr_d;
  logic [IDX_W-1:0]                 cur_idx;
  logic                             ph_en, ph_first, ph_end;
  logic                             blank_last;

  assign ph_en = (state_q == ST_SHIFT) || (state_q == ST_LATCH) || (state_q == ST_DISPLAY);

  miniled_clk_phase #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk_i        (I_clk),
    .rst_i        (sys_rst),
    .en_i         (ph_en),
    .first_half_o (ph_first),
    .period_end_o (ph_end)
  );

`ifdef SCAN_BLANK_EN
  localparam int KW = cnt_w(BLANK_CYC);
  logic [KW-1:0] blk_q;

  always_ff @(posedge I_clk) begin
    if (sys_rst || state_q != ST_BLANK) blk_q <= '0;
    else                                blk_q <= blk_q + KW'(1);
  end

  assign blank_last = (blk_q == KW'(BLANK_CYC - 1));
`else
  assign blank_last = 1'b1;
`endif

  assign cur_idx = IDX_W'(int'(s_q) * LED_PER_CHAN + int'(w_q));

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    w_d     = w_q;
    bit_d   = bit_q;
    pls_d   = pls_q;
    fph_d   = fph_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    case (state_q)
      ST_IDLE: begin
        if (light_refresh) begin
          state_d = ST_FETCH;
          s_d     = '0;
          w_d     = '0;
          fph_d   = 1'b0;
        end
      end
      ST_FETCH: begin
        if (!fph_q) begin
          fph_d = 1'b1;
          idx_d = cur_idx;
        end else begin
          fph_d   = 1'b0;
          sr_d    = fb.mapped_light;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ph_end) begin
          for (int c = 0; c < CHAN_NUM; c++) sr_d[c] = sr_q[c] << 1;
          if (bit_q == BW'(DATA_W - 1)) begin
            if (w_q == WW'(LED_PER_CHAN - 1)) begin
              state_d = ST_LATCH;
            end else begin
              w_d     = w_q + WW'(1);
              state_d = ST_FETCH;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      ST_LATCH: begin
        if (ph_end) begin
          state_d = ST_DISPLAY;
          pls_d   = '0;
        end
      end
      ST_DISPLAY: begin
        if (ph_end) begin
          if (pls_q == PW'(GCLK_PULSES - 1)) state_d = ST_BLANK;
          else                               pls_d   = pls_q + PW'(1);
        end
      end
      ST_BLANK: begin
        // Free-running: the last row wraps straight back to row 0.
        if (blank_last) begin
          state_d = ST_FETCH;
          w_d     = '0;
          s_d     = (s_q == SW'(SCAN_NUM - 1)) ? '0 : s_q + SW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      w_q     <= '0;
      bit_q   <= '0;
      pls_q   <= '0;
      fph_q   <= 1'b0;
      idx_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      w_q     <= w_d;
      bit_q   <= bit_d;
      pls_q   <= pls_d;
      fph_q   <= fph_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
    end
  end

  assign fb.light_index = (state_q == ST_FETCH && !fph_q) ? cur_idx : idx_q;

  always_comb begin
    for (int c = 0; c < CHAN_NUM; c++) SDI[c] = (state_q == ST_SHIFT) && sr_q[c][DATA_W-1];
    scan = '0;
    if (state_q == ST_DISPLAY) scan[s_q] = 1'b1;
  end

  assign DCLK       = (state_q == ST_SHIFT) && !ph_first;
  assign LE         = (state_q == ST_LATCH);
  assign GCLK       = (state_q == ST_DISPLAY) && ph_first;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_BLANK) && blank_last && (s_q == SW'(SCAN_NUM - 1));

endmodule

// File: tb/tb_miniled_scan_driver.sv
// Scan driver bench: cycle-by-cycle comparison against a timeline model plus literal spot checks.
module tb_miniled_scan_driver;

  localparam int SN = 2, CN = 2, L = 2, DW = 4, CD = 4, G = 3, BC = 5;
`ifdef SCAN_BLANK_EN
  localparam int B = BC;
`else
  localparam int B = 1;
`endif
  localparam int WL   = 2 + DW * CD;
  localparam int SLOT = L * WL + CD + G * CD + B;
  localparam int P    = SN * SLOT;

  typedef struct packed {
    logic       le;
    logic       dclk;
    logic [1:0] sdi;
    logic       gclk;
    logic [1:0] scan;
    logic       busy;
    logic       fd;
    logic [8:0] idx;
  } exp_t;

  logic       clk, sys_rst, light_refresh;
  logic       LE, DCLK, GCLK, busy, frame_done;
  logic [1:0] SDI, scan;
  logic [7:0] mem [0:3];

  int  checks = 0, failures = 0;
  bit  chk_en = 0, running = 0;
  int  k = 0;

  miniled_scan_driver_if #(.IDX_W(9), .CHAN_NUM(CN), .DATA_W(DW)) fb ();

  miniled_scan_driver #(
    .SCAN_NUM(SN), .CHAN_NUM(CN), .LED_PER_CHAN(L), .DATA_W(DW), .IDX_W(9),
    .CLK_DIV(CD), .GCLK_PULSES(G), .BLANK_CYC(BC)
  ) dut (
    .I_clk(clk), .sys_rst(sys_rst), .light_refresh(light_refresh), .fb(fb),
    .LE(LE), .DCLK(DCLK), .SDI(SDI), .GCLK(GCLK), .scan(scan),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    mem[0] = 8'h5A;  // lane0 = A, lane1 = 5
    mem[1] = 8'hC3;
    mem[2] = 8'h96;
    mem[3] = 8'h0F;
  end

  // Frame-buffer model: data appears one cycle after the address.
  always @(posedge clk)
    fb.mapped_light <= (fb.light_index < 9'd4) ? mem[fb.light_index[1:0]] : 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs kk cycles after the start pulse, from the frame timeline.
  function automatic exp_t model(input int kk);
    exp_t e;
    int o, s, w, p, b, c, o2, o3;
    e = '0;
    e.busy = 1'b1;
    s = (kk % P) / SLOT;
    o = (kk % P) % SLOT;
    if (o < L * WL) begin
      w = o / WL;
      p = o % WL;
      e.idx = 9'(s * L + w);
      if (p >= 2) begin
        b = (p - 2) / CD;
        c = (p - 2) % CD;
        e.dclk = (c >= CD / 2);
        for (int ch = 0; ch < CN; ch++) e.sdi[ch] = mem[s * L + w][ch * DW + DW - 1 - b];
      end
    end else begin
      e.idx = 9'(s * L + L - 1);
      o2 = o - L * WL;
      if (o2 < CD) e.le = 1'b1;
      else begin
        o3 = o2 - CD;
        if (o3 < G * CD) begin
          e.scan[s] = 1'b1;
          e.gclk = ((o3 % CD) < CD / 2);
        end else begin
          e.fd = (s == SN - 1) && (o3 - G * CD == B - 1);
        end
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (sys_rst) begin
      running <= 0;
      k       <= 0;
    end else if (running) k <= k + 1;
    else if (light_refresh) begin
      running <= 1;
      k       <= 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = running ? model(k) : exp_t'(0);
      chk("LE", LE, e.le);
      chk("DCLK", DCLK, e.dclk);
      chk("SDI", SDI, e.sdi);
      chk("GCLK", GCLK, e.gclk);
      chk("scan", scan, e.scan);
      chk("busy", busy, e.busy);
      chk("frame_done", frame_done, e.fd);
      chk("light_index", fb.light_index, e.idx);
    end
  end

  // Hand-computed spot values for the first frame and the reset point.
  always @(negedge clk) begin
    if (running) begin
      case (k)
        0:      begin chk("lit_idx0", fb.light_index, 0); chk("lit_busy0", busy, 1); end
        2:      begin chk("lit_sdi_b3", SDI, 2'b01); chk("lit_dclk_lo", DCLK, 0); end
        4:      chk("lit_dclk_hi", DCLK, 1);
        6:      chk("lit_sdi_b2", SDI, 2'b10);
        10:     chk("lit_sdi_b1", SDI, 2'b01);
        14:     chk("lit_sdi_b0", SDI, 2'b10);
        18:     chk("lit_idx1", fb.light_index, 1);
        40:     chk("lit_scan0", scan, 2'b01);
        P + 45: chk("lit_scan_pre_rst", scan, 2'b01);
        default: ;
      endcase
    end
  end

  int         dclk_s0 = 0, le_cyc = 0, gclk_rise = 0, fd_cnt = 0, gap = 0;
  logic       prev_dclk = 0, prev_gclk = 0;
  bit         seen01 = 0;
  logic [8:0] prev_idx = 0;
  int         idx_q[$];

  always @(negedge clk) begin
    if (running && k < P) begin
      if (DCLK && !prev_dclk && k < SLOT) dclk_s0++;
      if (LE) le_cyc++;
      if (GCLK && !prev_gclk) gclk_rise++;
      if (frame_done) fd_cnt++;
      if (scan == 2'b01) seen01 = 1;
      if (seen01 && scan == 2'b00 && fb.light_index == 9'd1) gap++;
    end
    if (busy && fb.light_index != prev_idx) idx_q.push_back(int'(fb.light_index));
    prev_dclk = DCLK;
    prev_gclk = GCLK;
    prev_idx  = fb.light_index;
  end

  initial begin
    sys_rst = 1;
    light_refresh = 0;
    @(posedge clk); #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1 light_refresh = 1;
    @(posedge clk); #1 light_refresh = 0; sys_rst = 0;
    repeat (20) @(posedge clk);
    #1 light_refresh = 1;
    @(posedge clk); #1 light_refresh = 0;
    repeat (30) @(posedge clk);
    #1 light_refresh = 1;
    @(posedge clk); #1 light_refresh = 0;
    repeat (P + 45 - 31) @(posedge clk);
    #1 sys_rst = 1;
    @(posedge clk); #1 sys_rst = 0;
    @(negedge clk);
    chk("rst_scan", scan, 0);
    chk("rst_gclk", GCLK, 0);
    chk("rst_busy", busy, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("dclk_rises_scan0", dclk_s0, 8);
    chk("le_cycles_frame", le_cyc, 2 * CD);
    chk("gclk_rises_frame", gclk_rise, 6);
    chk("frame_done_pulses", fd_cnt, 1);
    chk("blank_gap", gap, B);
    chk("idx_changes", (idx_q.size() >= 4) ? 1 : 0, 1);
    if (idx_q.size() >= 4) begin
      chk("idx_seq0", idx_q[0], 1);
      chk("idx_seq1", idx_q[1], 2);
      chk("idx_seq2", idx_q[2], 3);
      chk("idx_seq3", idx_q[3], 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
